// File: rtl/deadlock_idx0_monitor.sv
// ============================================================================
// Module   : deadlock_idx0_monitor
// Brief    : Per-kernel deadlock detector (instance 0). Asserts a registered
//            block flag after a stall on an unchanged blocked-vector persists.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module deadlock_idx0_monitor #(
    parameter int NUM_AXIS        = 2,
    parameter int NUM_INST        = 1,
    parameter int BLOCK_THRESHOLD = 1000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_AXIS-1:0] axis_block_sigs,
    input  logic [NUM_INST-1:0] inst_idle_sigs,
    input  logic [NUM_INST-1:0] inst_block_sigs,
    output logic                block
);

    localparam int              CNT_W      = $clog2(BLOCK_THRESHOLD + 1);
    localparam int              VEC_W      = NUM_AXIS + NUM_INST;
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(BLOCK_THRESHOLD - 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX  = CNT_W'(BLOCK_THRESHOLD);
    localparam bit              C_TH_ONE   = (BLOCK_THRESHOLD == 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COUNT   = 2'd1,
        ST_BLOCKED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [VEC_W-1:0]   vec_q,   vec_d;
    logic               block_q, block_d;

    logic [VEC_W-1:0]   vec_w;
    logic               all_idle_w;
    logic               stall_w;

    // A fully idle kernel has finished, so idle overrides any blocked flag.
    assign vec_w      = {inst_block_sigs, axis_block_sigs};
    assign all_idle_w = &inst_idle_sigs;
    assign stall_w    = (|vec_w) & ~all_idle_w;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            vec_q   <= '0;
            block_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            block_q <= block_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        block_d = block_q;
        case (state_q)
            ST_IDLE: begin
                if (stall_w) begin
                    cnt_d = C_CNT_ONE;
                    vec_d = vec_w;
                    if (C_TH_ONE) begin
                        block_d = 1'b1;
                        state_d = ST_BLOCKED;
                    end else begin
                        state_d = ST_COUNT;
                    end
                end
            end
            ST_COUNT: begin
                if (!stall_w) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (vec_w != vec_q) begin
                    // Any change in the blocked set is progress: restart.
                    cnt_d = C_CNT_ONE;
                    vec_d = vec_w;
                end else if (cnt_q >= C_CNT_LAST) begin
                    cnt_d   = C_CNT_MAX;
                    block_d = 1'b1;
                    state_d = ST_BLOCKED;
                end else begin
                    cnt_d = cnt_q + C_CNT_ONE;
                end
            end
            ST_BLOCKED: begin
                if (!stall_w) begin
                    cnt_d   = '0;
                    block_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                block_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign block = block_q;

endmodule

`default_nettype wire

// File: tb/tb_deadlock_idx0_monitor.sv
// ============================================================================
// Module   : tb_deadlock_idx0_monitor
// Brief    : Self-checking bench for deadlock_idx0_monitor, thresholds 4 and 1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_deadlock_idx0_monitor;

    logic       clock;
    logic       reset;
    logic [1:0] axis;
    logic [0:0] idle;
    logic [0:0] iblk;
    logic       block4;
    logic       block1;

    int checks;
    int fails;

    // History of {stall, vec} per edge, newest at index 0; one row per DUT.
    logic [3:0] hist [0:1][0:7];
    logic       mblk [0:1];
    int         th_of [0:1];

    deadlock_idx0_monitor #(.NUM_AXIS(2), .NUM_INST(1), .BLOCK_THRESHOLD(4)) u_dut4 (
        .clock           (clock),
        .reset           (reset),
        .axis_block_sigs (axis),
        .inst_idle_sigs  (idle),
        .inst_block_sigs (iblk),
        .block           (block4)
    );

    deadlock_idx0_monitor #(.NUM_AXIS(2), .NUM_INST(1), .BLOCK_THRESHOLD(1)) u_dut1 (
        .clock           (clock),
        .reset           (reset),
        .axis_block_sigs (axis),
        .inst_idle_sigs  (idle),
        .inst_block_sigs (iblk),
        .block           (block1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int m = 0; m < 2; m++) begin
            mblk[m] = 1'b0;
            for (int k = 0; k < 8; k++) hist[m][k] = 4'h0;
        end
    endtask

    // Deadlocked iff stalled now and either already deadlocked or the last
    // TH edges all saw a stall on exactly this vector.
    task automatic model_edge();
        logic [2:0] v;
        logic       st;
        logic       run_ok;
        v  = {iblk, axis};
        st = (v != 3'b000) && (idle != 1'b1);
        for (int m = 0; m < 2; m++) begin
            for (int k = 7; k > 0; k--) hist[m][k] = hist[m][k-1];
            hist[m][0] = {st, v};
            run_ok = 1'b1;
            for (int k = 0; k < th_of[m]; k++)
                if (hist[m][k] != {1'b1, v}) run_ok = 1'b0;
            mblk[m] = st && (mblk[m] || run_ok);
        end
    endtask

    task automatic step(input string tag, input logic [1:0] a, input logic i, input logic b);
        axis = a;
        idle = i;
        iblk = b;
        @(posedge clock);
        model_edge();
        #1;
        chk({tag, "/th4"}, block4, mblk[0]);
        chk({tag, "/th1"}, block1, mblk[1]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        axis  = 2'b00;
        idle  = 1'b0;
        iblk  = 1'b0;
        model_clear();
        @(posedge clock);
        #1;
        chk("reset_th4", block4, 1'b0);
        chk("reset_th1", block1, 1'b0);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        logic [1:0] ra;
        logic       ri;
        logic       rb;
        checks   = 0;
        fails    = 0;
        th_of[0] = 4;
        th_of[1] = 1;
        reset    = 1'b0;
        axis     = 2'b00;
        idle     = 1'b0;
        iblk     = 1'b0;
        model_clear();

        // Quiet inputs never block
        do_reset();
        for (int n = 0; n < 10; n++) step("quiet", 2'b00, 1'b0, 1'b0);

        // Steady stall: threshold-4 blocks after edge 4, threshold-1 after edge 1
        step("steady_e1", 2'b01, 1'b0, 1'b0);
        chk("steady_e1_const", block4, 1'b0);
        chk("th1_one_edge", block1, 1'b1);
        step("steady_e2", 2'b01, 1'b0, 1'b0);
        step("steady_e3", 2'b01, 1'b0, 1'b0);
        chk("steady_e3_const", block4, 1'b0);
        step("steady_e4", 2'b01, 1'b0, 1'b0);
        chk("steady_e4_const", block4, 1'b1);
        step("steady_hold", 2'b01, 1'b0, 1'b0);
        step("blocked_vec_change", 2'b10, 1'b0, 1'b0);
        chk("blocked_hold_const", block4, 1'b1);

        // Release drops block after one edge; re-stall needs a full count
        step("release", 2'b00, 1'b0, 1'b0);
        chk("release_const", block4, 1'b0);
        for (int n = 0; n < 3; n++) step("restall", 2'b11, 1'b0, 1'b0);
        chk("restall_e3_const", block4, 1'b0);
        step("restall_e4", 2'b11, 1'b0, 1'b0);
        chk("restall_e4_const", block4, 1'b1);

        // Vector change at edge 2 restarts the count: block after edge 5
        step("gap", 2'b00, 1'b0, 1'b0);
        step("chg_e1", 2'b01, 1'b0, 1'b0);
        for (int n = 0; n < 3; n++) step("chg_e2_4", 2'b10, 1'b0, 1'b0);
        chk("chg_e4_const", block4, 1'b0);
        step("chg_e5", 2'b10, 1'b0, 1'b0);
        chk("chg_e5_const", block4, 1'b1);

        // All-idle overrides blocked flags
        step("gap2", 2'b00, 1'b0, 1'b0);
        for (int n = 0; n < 20; n++) step("idle_override", 2'b11, 1'b1, 1'b1);
        chk("idle_override_const", block4, 1'b0);

        // Sub-instance blocked flag alone also stalls
        for (int n = 0; n < 4; n++) step("inst_blk", 2'b00, 1'b0, 1'b1);
        chk("inst_blk_const", block4, 1'b1);

        // Asynchronous reset while blocked clears block before the next edge
        #2 reset = 1'b1;
        #1;
        chk("async_rst_th4", block4, 1'b0);
        chk("async_rst_th1", block1, 1'b0);
        model_clear();
        @(negedge clock);
        axis = 2'b01;
        @(posedge clock);
        #1;
        chk("rst_held_th4", block4, 1'b0);
        chk("rst_held_th1", block1, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        step("post_rst", 2'b01, 1'b0, 1'b0);
        chk("post_rst_th1", block1, 1'b1);

        // Randomized sequences with sticky inputs so long stalls occur
        ra = 2'b00;
        ri = 1'b0;
        rb = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                ra = 2'($urandom_range(0, 3));
                ri = ($urandom_range(0, 7) == 0);
                rb = 1'($urandom_range(0, 1));
            end
            step("random", ra, ri, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        fails++;
        $display("FAIL timeout observed=running expected=finished");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
